// File: rtl/serv_nibble_pkg.sv
// Shared types and constants for the SERV nibble-serial host sequencer.
package serv_nibble_pkg;

  typedef enum logic [3:0] {
    ST_RST_CHIP,
    ST_IDLE,
    ST_ADR,
    ST_FETCH_D,
    ST_DRD,
    ST_FETCH_I,
    ST_INSN,
    ST_CAP,
    ST_CPU_HI,
    ST_CPU_LO
  } state_e;

  localparam int NIBBLES = 8;
  localparam int NIB_W   = 4;

  // Eight low/high slot pairs followed by one low tail segment.
  localparam int SEGS = 2 * NIBBLES + 1;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_ADDR = 1'b1;

  // States that run one buf_clk phase on the shared engine.
  function automatic logic is_phase(input state_e s);
    return (s == ST_ADR) || (s == ST_DRD) || (s == ST_INSN);
  endfunction

  // buf_sel value the chip expects for a given phase state.
  function automatic logic phase_sel(input state_e s);
    return (s == ST_INSN) ? SEL_DATA : SEL_ADDR;
  endfunction

endpackage

// File: rtl/nibble_phase_engine.sv
// One 8-slot + tail buf_clk phase: shifts a 32-bit word out LSB nibble first
// while collecting the 32-bit word the chip shifts back, one slot behind.
module nibble_phase_engine
  import serv_nibble_pkg::*;
#(
  parameter int HALF = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [NIBBLES*NIB_W-1:0]   i_tx,
  input  logic [NIB_W-1:0]           i_nib_in,
  output logic                       o_buf_clk,
  output logic [NIB_W-1:0]           o_nib_out,
  output logic [NIBBLES*NIB_W-1:0]   o_rx,
  output logic                       o_done
);

  localparam int HCW = (HALF > 1) ? $clog2(HALF) : 1;

  logic                          r_run;
  logic [HCW-1:0]                r_hcnt;
  logic [4:0]                    r_seg;
  logic [(NIBBLES-1)*NIB_W-1:0]  r_rx;

  logic       w_half_end;
  logic       w_last_seg;
  logic       w_sample;
  logic [2:0] w_rx_idx;
  logic [2:0] w_tx_idx;

  // Even segments are buf_clk low, odd are high; segment 16 is the tail.
  assign w_half_end = (r_hcnt == HCW'(HALF - 1));
  assign w_last_seg = (r_seg == 5'(SEGS - 1));
  assign w_sample   = r_run && !r_seg[0] && w_half_end && (r_seg != 5'd0);
  assign w_rx_idx   = 3'(r_seg[4:1] - 4'd1);
  assign w_tx_idx   = r_seg[4] ? 3'd7 : r_seg[3:1];

  assign o_buf_clk = r_run && r_seg[0];
  assign o_nib_out = r_run ? i_tx[{w_tx_idx, 2'b00} +: NIB_W] : '0;
  assign o_done    = r_run && w_last_seg && w_half_end;
  // Nibble 7 arrives on the done cycle itself, so it is forwarded live.
  assign o_rx      = {i_nib_in, r_rx};

  // Slot/half-period sequencing of the phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run  <= 1'b0;
      r_hcnt <= '0;
      r_seg  <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_hcnt <= '0;
      r_seg  <= '0;
    end else if (r_run) begin
      if (w_half_end) begin
        r_hcnt <= '0;
        r_seg  <= w_last_seg ? 5'd0 : r_seg + 5'd1;
        if (w_last_seg) r_run <= 1'b0;
      end else begin
        r_hcnt <= r_hcnt + HCW'(1);
      end
    end
  end

  // Collect nibbles 0..6 on the last low cycle of the following slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx <= '0;
    end else begin
      for (int k = 0; k < NIBBLES - 1; k++) begin
        if (w_sample && (w_rx_idx == 3'(k))) r_rx[k*NIB_W +: NIB_W] <= i_nib_in;
      end
    end
  end

endmodule

// File: rtl/serv_nibble_host.sv
// Host-side sequencer for the nibble-serial SERV port: per CPU step it reads
// the bus addresses, fetches data and instruction words, delivers them and
// clocks the CPU once.
module serv_nibble_host
  import serv_nibble_pkg::*;
#(
  parameter int HALF       = 1,
  parameter int RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  output logic        busy,
  output logic        pad_cpu_clk,
  output logic        pad_buf_clk,
  output logic        pad_buf_sel,
  output logic        pad_rst,
  output logic [3:0]  pad_nib_out,
  input  logic [3:0]  pad_nib_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] ibus_adr,
  output logic [15:0] dbus_adr,
  output logic [31:0] dbus_dat,
  output logic        cap_valid
);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_cnt;
  logic        r_sel;
  logic [31:0] r_data;
  logic [31:0] r_insn;
  logic [15:0] r_ibus;
  logic [15:0] r_dbus;
  logic [31:0] r_dat;

  logic        w_start;
  logic        w_done;
  logic        w_buf_clk;
  logic [3:0]  w_nib_out;
  logic [31:0] w_rx;
  logic [31:0] w_tx;
  logic        w_half_end;
  logic        w_mem_fire;

  assign w_half_end = (r_cnt == 16'(HALF - 1));
  assign w_mem_fire = mem_req && mem_ack;
  // The engine starts on the edge that enters a phase state, so the phase
  // occupies exactly the cycles spent in that state.
  assign w_start    = is_phase(w_next) && (w_next != r_state);

  nibble_phase_engine #(
    .HALF (HALF)
  ) u_engine (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (w_start),
    .i_tx      (w_tx),
    .i_nib_in  (pad_nib_in),
    .o_buf_clk (w_buf_clk),
    .o_nib_out (w_nib_out),
    .o_rx      (w_rx),
    .o_done    (w_done)
  );

  // State register and per-state cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST_CHIP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST_CHIP: if (r_cnt == 16'(RST_CYCLES - 1)) w_next = ST_IDLE;
      ST_IDLE:     if (run || step) w_next = ST_ADR;
      ST_ADR:      if (w_done) w_next = ST_FETCH_D;
      ST_FETCH_D:  if (w_mem_fire) w_next = ST_DRD;
      ST_DRD:      if (w_done) w_next = ST_FETCH_I;
      ST_FETCH_I:  if (w_mem_fire) w_next = ST_INSN;
      ST_INSN:     if (w_done) w_next = ST_CAP;
      ST_CAP:      w_next = ST_CPU_HI;
      ST_CPU_HI:   if (w_half_end) w_next = ST_CPU_LO;
      ST_CPU_LO:   if (w_half_end) w_next = run ? ST_ADR : ST_IDLE;
      default:     w_next = ST_RST_CHIP;
    endcase
  end

  // Word shifted out by the current phase and the address presented to memory.
  always_comb begin
    w_tx     = '0;
    mem_addr = '0;
    case (r_state)
      ST_DRD:     w_tx = r_data;
      ST_INSN:    w_tx = r_insn;
      ST_FETCH_D: mem_addr = r_dbus;
      ST_FETCH_I: mem_addr = r_ibus;
      default:    ;
    endcase
  end

  // buf_sel only moves on a phase start, while buf_clk is still low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= SEL_DATA;
    end else if (w_start) begin
      r_sel <= phase_sel(w_next);
    end
  end

  // Capture bus addresses, fetched words and store data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ibus <= '0;
      r_dbus <= '0;
      r_dat  <= '0;
      r_data <= '0;
      r_insn <= '0;
    end else begin
      if (r_state == ST_ADR && w_done) begin
        r_ibus <= w_rx[15:0];
        r_dbus <= w_rx[31:16];
      end
      if (r_state == ST_FETCH_D && w_mem_fire) r_data <= mem_rdata;
      if (r_state == ST_FETCH_I && w_mem_fire) r_insn <= mem_rdata;
      if (r_state == ST_INSN && w_done) r_dat <= w_rx;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign pad_rst     = (r_state == ST_RST_CHIP);
  assign pad_cpu_clk = (r_state == ST_CPU_HI);
  assign pad_buf_clk = w_buf_clk;
  assign pad_buf_sel = r_sel;
  assign pad_nib_out = w_nib_out;
  assign mem_req     = (r_state == ST_FETCH_D) || (r_state == ST_FETCH_I);
  assign cap_valid   = (r_state == ST_CAP);
  assign ibus_adr    = r_ibus;
  assign dbus_adr    = r_dbus;
  assign dbus_dat    = r_dat;

endmodule

// File: tb/tb_serv_nibble_host.sv
// Bench for serv_nibble_host with a nibble-serial chip model and a memory model.
module tb_serv_nibble_host;

  localparam int HALF       = 3;
  localparam int RST_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n, run, step;
  logic        busy, pad_cpu_clk, pad_buf_clk, pad_buf_sel, pad_rst;
  logic [3:0]  pad_nib_out, pad_nib_in;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, ibus_adr, dbus_adr;
  logic [31:0] mem_rdata, dbus_dat;
  logic        cap_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_nibble_host #(.HALF(HALF), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .busy(busy),
    .pad_cpu_clk(pad_cpu_clk), .pad_buf_clk(pad_buf_clk), .pad_buf_sel(pad_buf_sel),
    .pad_rst(pad_rst), .pad_nib_out(pad_nib_out), .pad_nib_in(pad_nib_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ibus_adr(ibus_adr), .dbus_adr(dbus_adr), .dbus_dat(dbus_dat), .cap_valid(cap_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  // ---------------- chip model ----------------
  logic [15:0] chip_ibus, chip_dbus;
  logic [31:0] chip_store, chip_word;
  logic [2:0]  chip_ctr, chip_last;
  logic [3:0]  chip_out;

  always @(posedge pad_buf_clk or posedge pad_rst) begin
    if (pad_rst) begin
      chip_ctr  <= 3'd0;
      chip_last <= 3'd0;
      chip_out  <= 4'd0;
    end else begin
      chip_word = pad_buf_sel ? {chip_dbus, chip_ibus} : chip_store;
      chip_out  <= chip_word[{chip_ctr, 2'b00} +: 4];
      chip_last <= chip_ctr;
      chip_ctr  <= chip_ctr + 3'd1;
    end
  end
  assign pad_nib_in = chip_out;

  // ---------------- memory model ----------------
  int          hold = 1;
  int          wait_cnt = 0;
  logic [31:0] mem_data, mem_insn;

  assign mem_ack   = mem_req && (wait_cnt >= hold - 1);
  assign mem_rdata = !mem_req ? 32'h0 :
                     (mem_addr == chip_dbus) ? mem_data :
                     (mem_addr == chip_ibus) ? mem_insn : 32'hBAD0BAD0;

  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  // ---------------- behavioural model and compare ----------------
  int          ridx = 0, fetch_idx = 0, cpu_pulses = 0, caps = 0, cyc = 0, last_cap = 0;
  bit          have_cap = 0, check_len = 0, rec_en = 0;
  int          exp_len = 162;
  logic        prev_buf = 0, prev_cpu = 0, prev_req = 0, prev_sel = 0, prev_busy = 0;
  logic [31:0] drd_seq = 0, ins_seq = 0;

  function automatic logic [31:0] exp_tx(input int ph);
    return (ph == 1) ? mem_data : (ph == 2) ? mem_insn : 32'h0;
  endfunction

  always @(negedge clk) begin
    logic [31:0] wv;
    int ph, k;
    cyc++;
    if (pad_rst) begin
      ridx = 0; fetch_idx = 0; cpu_pulses = 0; have_cap = 0;
    end else begin
      if (pad_buf_clk && !prev_buf) begin
        ph = ridx / 8;
        k  = ridx % 8;
        chk("rise_in_step", 32'(ridx < 24), 32'd1);
        if (ph < 3) begin
          wv = exp_tx(ph);
          chk("nib_out", 32'(pad_nib_out), 32'(wv[k*4 +: 4]));
          chk("buf_sel", 32'(pad_buf_sel), 32'(ph < 2));
          chk("chip_align", 32'(chip_last), 32'(k));
          if (rec_en && ph == 1) drd_seq = {drd_seq[27:0], pad_nib_out};
          if (rec_en && ph == 2) ins_seq = {ins_seq[27:0], pad_nib_out};
        end
        if (ridx == 0 && have_cap) begin
          chk("cpu_pulses_run", 32'(cpu_pulses), 32'd1);
          cpu_pulses = 0;
        end
        ridx++;
      end
      if (pad_buf_sel != prev_sel) begin
        chk("sel_chg_buf_low", 32'(pad_buf_clk), 32'd0);
        chk("sel_chg_boundary", 32'(ridx % 8), 32'd0);
      end
      if (mem_req) begin
        chk("mem_addr", 32'(mem_addr), 32'(fetch_idx == 0 ? chip_dbus : chip_ibus));
        chk("buf_low_in_fetch", 32'(pad_buf_clk), 32'd0);
        chk("fetch_pos", 32'(ridx), 32'(8 * (fetch_idx + 1)));
      end
      if (!mem_req && prev_req) fetch_idx++;
      if (pad_cpu_clk) chk("cpu_while_buf", 32'(pad_buf_clk), 32'd0);
      if (pad_cpu_clk && !prev_cpu) cpu_pulses++;
      if (cap_valid) begin
        chk("cap_ibus", 32'(ibus_adr), 32'(chip_ibus));
        chk("cap_dbus", 32'(dbus_adr), 32'(chip_dbus));
        chk("cap_dat", dbus_dat, chip_store);
        chk("rises_at_cap", 32'(ridx), 32'd24);
        chk("fetches_at_cap", 32'(fetch_idx), 32'd2);
        chk("cpu_before_cap", 32'(cpu_pulses), 32'd0);
        if (have_cap && check_len) chk("step_len", 32'(cyc - last_cap), 32'(exp_len));
        ridx = 0; fetch_idx = 0; caps++; last_cap = cyc; have_cap = 1;
      end
      if (!busy && prev_busy) begin
        if (have_cap) chk("cpu_pulses_step", 32'(cpu_pulses), 32'd1);
        cpu_pulses = 0;
        have_cap = 0;
      end
    end
    prev_buf = pad_buf_clk; prev_cpu = pad_cpu_clk; prev_req = mem_req;
    prev_sel = pad_buf_sel; prev_busy = busy;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_step();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    fail_timeout(nm);
  endtask

  task automatic wait_req_len(input string nm, output int len);
    len = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    if (!mem_req) begin
      fail_timeout(nm);
      return;
    end
    while (mem_req && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, caps0, rises;
    bit pads_ok;
    rst_n = 1'b1; run = 1'b0; step = 1'b0;
    chip_ibus = 16'h1234; chip_dbus = 16'hABCD; chip_store = 32'hCAFEF00D;
    mem_data = 32'h12345678; mem_insn = 32'hDEADBEEF;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pad_rst", 32'(pad_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pads", {26'd0, pad_cpu_clk, pad_buf_clk, pad_buf_sel, mem_req, cap_valid, |pad_nib_out}, 32'd0);
    chk("rst_caps", {ibus_adr, dbus_adr} | dbus_dat | 32'(mem_addr), 32'd0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0; pads_ok = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!pad_rst) break;
      n++;
      if (pad_cpu_clk || pad_buf_clk || pad_buf_sel || pad_nib_out != 0 || mem_req) pads_ok = 0;
    end
    chk("rst_len", 32'(n), 32'd16);
    chk("rst_pads_quiet", 32'(pads_ok), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single step, zero-wait memory, plus an ignored step while busy.
    rec_en = 1;
    pulse_step();
    wait_req_len("step1_req_d", len);
    chk("hold_zero_wait", 32'(len), 32'd1);
    pulse_step();
    wait_idle("step1_idle");
    rec_en = 0;
    chk("step1_caps", 32'(caps), 32'd1);
    chk("step1_ibus", 32'(ibus_adr), 32'h1234);
    chk("step1_dbus", 32'(dbus_adr), 32'hABCD);
    chk("step1_dat", dbus_dat, 32'hCAFEF00D);
    chk("drd_nibbles", drd_seq, 32'h87654321);
    chk("insn_nibbles", ins_seq, 32'hFEEBDAED);
    repeat (10) @(negedge clk);
    chk("step_ignored", 32'(busy), 32'd0);

    // Slow memory, then reset asserted in the middle of DRD.
    chip_ibus = 16'h0100; chip_dbus = 16'h0200; chip_store = 32'h11112222;
    mem_data = 32'h0BADF00D; mem_insn = 32'h00000013;
    hold = 3;
    caps0 = caps;
    pulse_step();
    wait_req_len("abort_req_d", len);
    chk("hold_three", 32'(len), 32'd3);
    rises = 0;
    for (int i = 0; i < 400 && rises < 5; i++) begin
      @(negedge clk);
      if (pad_buf_clk && !prev_buf) rises++;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_pad_rst", 32'(pad_rst), 32'd1);
    chk("abort_buf_clk", 32'(pad_buf_clk), 32'd0);
    chk("abort_ibus", 32'(ibus_adr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("abort_rst_idle");
    chk("abort_no_cap", 32'(caps - caps0), 32'd0);
    pulse_step();
    wait_idle("realign_idle");
    chk("realign_caps", 32'(caps - caps0), 32'd1);
    chk("realign_ibus", 32'(ibus_adr), 32'h0100);
    chk("realign_dbus", 32'(dbus_adr), 32'h0200);
    chk("realign_dat", dbus_dat, 32'h11112222);

    // Free-running steps; run+step start once, run drop finishes the step.
    chip_ibus = 16'h0F0F; chip_dbus = 16'h8001; chip_store = 32'hFFFFFFFF;
    mem_data = 32'h00000000; mem_insn = 32'hA5A5A5A5;
    hold = 1;
    check_len = 1;
    caps0 = caps;
    @(posedge clk); #1 run = 1'b1; step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    for (int i = 0; i < 3000 && (caps - caps0) < 4; i++) @(negedge clk);
    if ((caps - caps0) < 4) fail_timeout("run_caps4");
    repeat (20) @(posedge clk);
    #1 run = 1'b0;
    wait_idle("run_idle");
    chk("run_caps", 32'(caps - caps0), 32'd5);
    check_len = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
